// File: rtl/rng_arbiter.sv
// Round-robin arbiter handing out words from a 32-bit Fibonacci LFSR.
// The LFSR warms up after reset or seed load, then advances only on grants so no word is issued twice.
module rng_arbiter #(
  parameter int NREQ   = 4,
  parameter int WARMUP = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            seed_we,
  input  logic [31:0]     seed,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [31:0]     rnd_data,
  output logic            ready,
  output logic [15:0]     grant_cnt
);
  localparam int          PW        = $clog2(NREQ);
  localparam logic [31:0] SEED_DEF  = 32'h1ACE_B00C;
  localparam logic [0:0]  WARM      = 1'b0;
  localparam logic [0:0]  RUN       = 1'b1;
  localparam logic [7:0]  WARM_LAST = 8'(WARMUP - 1);

  logic [31:0]   r;
  logic [31:0]   r_next;
  logic [0:0]    state;
  logic [7:0]    warm_cnt;
  logic [PW-1:0] ptr;
  logic [PW-1:0] gnt_idx;
  logic          any_gnt;

  assign r_next   = {r[30:0], r[31] ^ r[21] ^ r[1] ^ r[0]};
  assign rnd_data = r;
  assign ready    = (state == RUN);
  assign any_gnt  = |gnt;

  // First set request at or above ptr, wrapping; seed load blocks grants.
  always_comb begin
    int   idx;
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    if (state == RUN && !seed_we) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (int'(ptr) + k) % NREQ;
        if (!found && req[idx]) begin
          found    = 1'b1;
          gnt[idx] = 1'b1;
          gnt_idx  = PW'(idx);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r         <= SEED_DEF;
      state     <= WARM;
      warm_cnt  <= '0;
      ptr       <= '0;
      grant_cnt <= '0;
    end else begin
      if (seed_we) begin
        r        <= (seed == 32'd0) ? SEED_DEF : seed;
        warm_cnt <= '0;
        state    <= WARM;
      end else if (state == WARM) begin
        r <= r_next;
        if (warm_cnt == WARM_LAST) begin
          state    <= RUN;
          warm_cnt <= '0;
        end else begin
          warm_cnt <= warm_cnt + 8'd1;
        end
      end else if (any_gnt) begin
        r   <= r_next;
        ptr <= (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);
      end
      if (any_gnt && grant_cnt != 16'hFFFF)
        grant_cnt <= grant_cnt + 16'd1;
    end
  end
endmodule
